// File: rtl/ukf_pkg.sv
// ukf_pkg: shared state encoding, fixed-point constants and output saturation for the UKF weight sequencer.
`timescale 1ns/1ps
package ukf_pkg;

  localparam int unsigned UKF_DATA_W        = 32;
  localparam int unsigned UKF_FRAC_BITS     = 30;
  localparam int unsigned UKF_OUT_FRAC_BITS = 16;
  localparam int unsigned SAT_IN_W          = 64;

  localparam logic [UKF_DATA_W-1:0] ONE_Q30 = 32'h4000_0000;
  localparam logic [UKF_DATA_W-1:0] ONE_Q16 = 32'h0001_0000;
  localparam logic [UKF_DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [UKF_DATA_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_A2,
    ST_S,
    ST_CHK,
    ST_DIV,
    ST_W0,
    ST_C,
    ST_DONE
  } ukf_state_e;

  typedef struct packed {
    logic                  clip;
    logic [UKF_DATA_W-1:0] val;
  } sat_word_t;

  // Clamp a wide signed value into a signed output word and flag whether it was clipped.
  function automatic sat_word_t sat_to_word(input logic signed [SAT_IN_W-1:0] x);
    sat_word_t r;
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    hi     = SAT_IN_W'($signed(SAT_MAX));
    lo     = SAT_IN_W'($signed(SAT_MIN));
    r.clip = 1'b1;
    r.val  = SAT_MAX;
    if (x > hi) begin
      r.val = SAT_MAX;
    end else if (x < lo) begin
      r.val = SAT_MIN;
    end else begin
      r.clip = 1'b0;
      r.val  = x[UKF_DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/ukf_seq_divider.sv
// ukf_seq_divider: iterative restoring unsigned divider, one quotient bit per cycle.
// The start cycle already produces the first bit, so done_c is high during the cycle that
// writes the final bit and the registered quotient is complete from the following cycle.
`timescale 1ns/1ps
module ukf_seq_divider #(
  parameter int unsigned QW = 48
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [QW-1:0] dividend,
  input  logic [QW-1:0] divisor,
  output logic          done_c,
  output logic [QW-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(QW + 1);

  logic [QW-1:0]    rem_q;
  logic [QW-1:0]    dsr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;

  logic [QW-1:0]    rem_src;
  logic [QW-1:0]    quo_src;
  logic [QW-1:0]    dsr_src;
  logic [QW:0]      rem_sh;
  logic [QW-1:0]    rem_nxt;
  logic [QW-1:0]    quo_nxt;

  // One restoring step; on start the step works directly on the fresh operands.
  always_comb begin
    rem_src = start ? '0 : rem_q;
    quo_src = start ? dividend : quotient;
    dsr_src = start ? divisor : dsr_q;
    rem_sh  = {rem_src, quo_src[QW-1]};
    rem_nxt = rem_sh[QW-1:0];
    quo_nxt = {quo_src[QW-2:0], 1'b0};
    if (rem_sh >= {1'b0, dsr_src}) begin
      rem_nxt = QW'(rem_sh - {1'b0, dsr_src});
      quo_nxt = {quo_src[QW-2:0], 1'b1};
    end
  end

  // Iteration registers; a new start restarts the division from scratch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rem_q    <= '0;
      dsr_q    <= '0;
      quotient <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start || run_q) begin
      rem_q    <= rem_nxt;
      quotient <= quo_nxt;
      if (start) begin
        dsr_q <= divisor;
        cnt_q <= CNT_W'(QW - 1);
        run_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          run_q <= 1'b0;
        end
      end
    end
  end

  assign done_c = run_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ukf_weight_seq.sv
// ukf_weight_seq: multi-cycle computation of the UKF sigma-point weights w, w0m, w0c
// from alpha, beta, kappa using one shared multiplier and an iterative divider.
`timescale 1ns/1ps
module ukf_weight_seq
  import ukf_pkg::*;
#(
  parameter int unsigned N_STATE       = 6,
  parameter int unsigned DATA_W        = UKF_DATA_W,
  parameter int unsigned FRAC_BITS     = UKF_FRAC_BITS,
  parameter int unsigned OUT_FRAC_BITS = UKF_OUT_FRAC_BITS
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] alpha,
  input  logic [DATA_W-1:0] beta,
  input  logic [DATA_W-1:0] kappa,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic              err,
  output logic              sat,
  output logic [DATA_W-1:0] w0m,
  output logic [DATA_W-1:0] w0c,
  output logic [DATA_W-1:0] w
);

  // Intermediate widths sized so that no step can wrap for N_STATE up to 15.
  localparam int unsigned A2_W    = 2*DATA_W - FRAC_BITS;
  localparam int unsigned SUM_W   = DATA_W + 3;
  localparam int unsigned S_W     = A2_W + SUM_W - FRAC_BITS;
  localparam int unsigned LAM_W   = S_W + 1;
  localparam int unsigned DIV_W   = DATA_W + OUT_FRAC_BITS;
  localparam int unsigned MUL_A_W = LAM_W;
  localparam int unsigned MUL_B_W = DIV_W + 1;
  localparam int unsigned PROD_W  = MUL_A_W + MUL_B_W;
  localparam int unsigned W0_W    = PROD_W - FRAC_BITS;
  localparam int unsigned Q_SHIFT = FRAC_BITS - OUT_FRAC_BITS;

  localparam logic [DIV_W-1:0]        DIVIDEND = DIV_W'(1) << (FRAC_BITS + OUT_FRAC_BITS);
  localparam logic [SUM_W-1:0]        N_SUM    = SUM_W'(N_STATE) << FRAC_BITS;
  localparam logic signed [LAM_W-1:0] N_LAM    = LAM_W'(N_STATE) << FRAC_BITS;

  ukf_state_e state_q;
  ukf_state_e state_d;

  logic [DATA_W-1:0]         alpha_q;
  logic [DATA_W-1:0]         beta_q;
  logic [DATA_W-1:0]         kappa_q;
  logic [A2_W-1:0]           a2_q;
  logic [S_W-1:0]            s_q;
  logic signed [LAM_W-1:0]   lam_q;
  logic signed [W0_W-1:0]    w0m_raw_q;

  logic [SUM_W-1:0]          sum_v;
  logic signed [MUL_A_W-1:0] mul_a;
  logic signed [MUL_B_W-1:0] mul_b;
  logic signed [PROD_W-1:0]  prod;
  logic signed [W0_W-1:0]    prod_sh;
  logic signed [SAT_IN_W-1:0] w0c_x;
  logic                      div_start;
  logic                      div_done_c;
  logic [DIV_W-1:0]          quo;
  sat_word_t                 w_sat;
  sat_word_t                 w0m_sat;
  sat_word_t                 w0c_sat;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_A2;
      ST_A2:   state_d = ST_S;
      ST_S:    state_d = ST_CHK;
      ST_CHK:  state_d = (s_q == '0) ? ST_DONE : ST_DIV;
      ST_DIV:  if (div_done_c) state_d = ST_W0;
      ST_W0:   state_d = ST_C;
      ST_C:    state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shared multiplier operand selection: alpha^2, a2*(L+kappa), lambda*q.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      ST_A2: begin
        mul_a = MUL_A_W'({1'b0, alpha_q});
        mul_b = MUL_B_W'({1'b0, alpha_q});
      end
      ST_S: begin
        mul_a = MUL_A_W'({1'b0, a2_q});
        mul_b = MUL_B_W'({1'b0, sum_v});
      end
      ST_W0: begin
        mul_a = lam_q;
        mul_b = {1'b0, quo};
      end
      default: ;
    endcase
  end

  assign sum_v   = N_SUM + SUM_W'(kappa_q);
  assign prod    = PROD_W'(mul_a) * PROD_W'(mul_b);
  assign prod_sh = W0_W'(prod >>> FRAC_BITS);

  // w0c before saturation: w0m + 1 - alpha^2 + beta, all in Q.16.
  assign w0c_x = SAT_IN_W'(w0m_raw_q) + SAT_IN_W'(ONE_Q16)
               - SAT_IN_W'(a2_q >> Q_SHIFT) + SAT_IN_W'(beta_q >> Q_SHIFT);

  assign w_sat   = sat_to_word(SAT_IN_W'(quo));
  assign w0m_sat = sat_to_word(SAT_IN_W'(w0m_raw_q));
  assign w0c_sat = sat_to_word(w0c_x);

  // Divider computes 2^(FRAC+OUT_FRAC) / (2*s) once s is known to be non-zero.
  assign div_start = (state_q == ST_CHK) && (s_q != '0);

  ukf_seq_divider #(
    .QW (DIV_W)
  ) u_div (
    .clk      (clk),
    .rstn     (rstn),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (DIV_W'({s_q, 1'b0})),
    .done_c   (div_done_c),
    .quotient (quo)
  );

  // Datapath registers and registered outputs, advanced by the current state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alpha_q   <= '0;
      beta_q    <= '0;
      kappa_q   <= '0;
      a2_q      <= '0;
      s_q       <= '0;
      lam_q     <= '0;
      w0m_raw_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      err       <= 1'b0;
      sat       <= 1'b0;
      w0m       <= '0;
      w0c       <= '0;
      w         <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            alpha_q <= alpha;
            beta_q  <= beta;
            kappa_q <= kappa;
            busy    <= 1'b1;
            valid   <= 1'b0;
          end
        end
        ST_A2: a2_q <= prod_sh[A2_W-1:0];
        ST_S:  s_q  <= prod_sh[S_W-1:0];
        ST_CHK: begin
          if (s_q == '0) begin
            w0m   <= '0;
            w0c   <= '0;
            w     <= '0;
            err   <= 1'b1;
            sat   <= 1'b0;
            done  <= 1'b1;
            valid <= 1'b1;
            busy  <= 1'b0;
          end else begin
            lam_q <= $signed({1'b0, s_q}) - N_LAM;
          end
        end
        ST_W0: w0m_raw_q <= prod_sh;
        ST_C: begin
          w     <= w_sat.val;
          w0m   <= w0m_sat.val;
          w0c   <= w0c_sat.val;
          sat   <= w_sat.clip | w0m_sat.clip | w0c_sat.clip;
          err   <= 1'b0;
          done  <= 1'b1;
          valid <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ukf_weight_seq.sv
// tb_ukf_weight_seq: directed vectors with hand-computed weights; a scoreboard queue is
// filled at each start and a monitor checks every done pulse against it.
`timescale 1ns/1ps
module tb_ukf_weight_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] alpha;
  logic [31:0] beta;
  logic [31:0] kappa;
  logic        busy;
  logic        done;
  logic        valid;
  logic        err;
  logic        sat;
  logic [31:0] w0m;
  logic [31:0] w0c;
  logic [31:0] w;

  ukf_weight_seq dut (
    .clk   (clk),
    .rstn  (rstn),
    .start (start),
    .alpha (alpha),
    .beta  (beta),
    .kappa (kappa),
    .busy  (busy),
    .done  (done),
    .valid (valid),
    .err   (err),
    .sat   (sat),
    .w0m   (w0m),
    .w0c   (w0c),
    .w     (w)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] w;
    logic [31:0] w0m;
    logic [31:0] w0c;
    logic        err;
    logic        sat;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_latency"}, 32'(cyc), 32'(mon_e.due));
        check({mon_e.name, "_w"},       w,        mon_e.w);
        check({mon_e.name, "_w0m"},     w0m,      mon_e.w0m);
        check({mon_e.name, "_w0c"},     w0c,      mon_e.w0c);
        check({mon_e.name, "_err"},     32'(err), 32'(mon_e.err));
        check({mon_e.name, "_sat"},     32'(sat), 32'(mon_e.sat));
        check({mon_e.name, "_valid"},   32'(valid), 32'd1);
      end
    end
  end

  // Pulse start with the given inputs (caller sits at a negedge) and queue the expectation.
  task automatic issue(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] k, input logic [31:0] ew, input logic [31:0] ew0m,
                       input logic [31:0] ew0c, input logic eerr, input logic esat);
    exp_t e;
    alpha  = a;
    beta   = b;
    kappa  = k;
    start  = 1'b1;
    e.name = name;
    e.w    = ew;
    e.w0m  = ew0m;
    e.w0c  = ew0c;
    e.err  = eerr;
    e.sat  = esat;
    e.due  = cyc + (eerr ? 4 : 53);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    alpha = ~a;
    beta  = ~b;
    kappa = ~k;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d results pending after %0d cycles expected 0", sb.size(), max_cyc);
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] k, input logic [31:0] ew, input logic [31:0] ew0m,
                     input logic [31:0] ew0c, input logic eerr, input logic esat);
    issue(name, a, b, k, ew, ew0m, ew0c, eerr, esat);
    check({name, "_valid_drop"}, 32'(valid), 32'd0);
    check({name, "_busy"},       32'(busy),  32'd1);
    drain(80);
    check({name, "_hold_w"},     w,          ew);
    check({name, "_hold_valid"}, 32'(valid), 32'd1);
    check({name, "_idle_busy"},  32'(busy),  32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_w"},     w,          32'd0);
    check({name, "_w0m"},   w0m,        32'd0);
    check({name, "_w0c"},   w0c,        32'd0);
    check({name, "_busy"},  32'(busy),  32'd0);
    check({name, "_done"},  32'(done),  32'd0);
    check({name, "_valid"}, 32'(valid), 32'd0);
    check({name, "_err"},   32'(err),   32'd0);
    check({name, "_sat"},   32'(sat),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time %0t expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn  = 1'b0;
    start = 1'b0;
    alpha = '0;
    beta  = '0;
    kappa = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // alpha=1, beta=2, kappa=0: lambda=0, w=1/12
    run("unity",   32'h4000_0000, 32'h8000_0000, 32'h0000_0000,
                   32'h0000_1555, 32'h0000_0000, 32'h0002_0000, 1'b0, 1'b0);
    // alpha=0.5: lambda=-4.5, w=1/3
    run("half",    32'h2000_0000, 32'h8000_0000, 32'h0000_0000,
                   32'h0000_5555, 32'hFFFE_8001, 32'h0001_4001, 1'b0, 1'b0);
    // alpha=1, beta=0, kappa=3: lambda=3, w=1/18
    run("kappa3",  32'h4000_0000, 32'h0000_0000, 32'hC000_0000,
                   32'h0000_0E38, 32'h0000_2AA8, 32'h0000_2AA8, 1'b0, 1'b0);
    // alpha=0 gives L+lambda=0
    run("divzero", 32'h0000_0000, 32'h8000_0000, 32'h4000_0000,
                   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    // tiny alpha: huge w and very negative w0m/w0c clip
    run("satur",   32'h0010_0000, 32'h8000_0000, 32'h0000_0000,
                   32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);

    // second start and input changes while busy are ignored
    issue("restart", 32'h4000_0000, 32'h8000_0000, 32'h0000_0000,
                     32'h0000_1555, 32'h0000_0000, 32'h0002_0000, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    alpha = 32'h2000_0000;
    beta  = 32'h0000_0000;
    kappa = 32'h4000_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    alpha = 32'h0000_0000;
    check("restart_busy", 32'(busy), 32'd1);
    drain(80);

    // reset in the middle of a run aborts it with no done
    issue("abort", 32'h2000_0000, 32'h8000_0000, 32'h0000_0000,
                   32'h0000_5555, 32'hFFFE_8001, 32'h0001_4001, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    #2 rstn = 1'b0;
    #1 check_all_zero("midreset");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (60) @(negedge clk);
    run("after_reset", 32'h2000_0000, 32'h8000_0000, 32'h0000_0000,
                       32'h0000_5555, 32'hFFFE_8001, 32'h0001_4001, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ukf_weight_seq.md
Name: ukf_weight_seq

Overview:
Multi-cycle sequencer that computes the UKF sigma-point weights (lambda, W0m, W0c, Wi) from alpha, beta and kappa.
It uses one shared multiplier and one iterative divider instead of a fully combinational weight datapath.
It runs once per filter (re)configuration, under a start/done handshake from the filter top-level controller.
It holds its results stable for the predict/update stages until the next start.

Parameters:
N_STATE, 6, state dimension L (unsigned integer, 1..15)
DATA_W, 32, width of every input and output word
FRAC_BITS, 30, fractional bits of inputs (unsigned Q2.30)
OUT_FRAC_BITS, 16, fractional bits of outputs (signed Q16.16)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
alpha  in  DATA_W  unsigned Q2.30
beta  in  DATA_W  unsigned Q2.30
kappa  in  DATA_W  unsigned Q2.30
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse when results are written
valid  out  1  results valid; high from done until the next accepted start
err  out  1  L+lambda == 0 (division by zero); valid with done
sat  out  1  some output was saturated; valid with done
w0m  out  DATA_W  signed Q16.16, lambda/(2(L+lambda))
w0c  out  DATA_W  signed Q16.16, w0m + 1 - alpha^2 + beta
w  out  DATA_W  signed Q16.16, 1/(2(L+lambda))

Behaviour:
- Reset (async, any state): FSM to IDLE. All outputs 0. Divider cleared.
- Accepted start: alpha/beta/kappa captured into internal registers at the start edge. Later input changes are ignored.
- start while busy: ignored, no queuing.
- FSM states and transitions:
  - IDLE -> A2 on start.
  - A2: a2 = (alpha*alpha) >> FRAC_BITS, unsigned Q4.30.
  - S: s = (a2*(N_STATE<<FRAC_BITS + kappa)) >> FRAC_BITS, unsigned. s = L+lambda.
  - CHK:
    - If s == 0: go to DONE with err=1 and all outputs 0.
    - Else: lambda = s - (N_STATE<<FRAC_BITS), signed Q.30; go to DIV.
  - DIV: restoring divider, one quotient bit per cycle, DIV_W = DATA_W+OUT_FRAC_BITS cycles.
    - Quotient q = floor(2^(FRAC_BITS+OUT_FRAC_BITS) / (2*s)), Q.16.
  - W0: w0m_raw = (lambda*q) >>> FRAC_BITS, arithmetic shift (floor).
  - C: w0c_raw = w0m_raw + ((1<<16) - (a2>>14) + (beta>>14)).
  - DONE: saturate q, w0m_raw and w0c_raw to signed DATA_W (0x7FFFFFFF / 0x80000000). Set sat if any clipped. Register outputs. Pulse done, set valid. Return to IDLE next cycle.
- Latency:
  - Normal: done high in cycle start+DIV_W+5 (53 with defaults).
  - Error: done high in cycle start+4.
- Internal arithmetic must be wide enough that no intermediate wraps. Products are full width before shifting.
- Outputs hold their last values until the next DONE or reset. valid drops the cycle after an accepted start.
- Reset mid-operation aborts the run with no done pulse.

Decomposition:
- Shared package ukf_pkg holds:
  - FSM state enum
  - fixed-point constants: ONE_Q30, ONE_Q16, SAT_MAX, SAT_MIN
  - saturate-to-DATA_W function
- One sub-module, ukf_seq_divider: iterative restoring unsigned divider.
  - Handshake: start/done.
  - Parameterised on quotient width.
  - Reused later by the covariance-inverse block.

Test Plan:
- alpha=0x40000000 (1.0), beta=0x80000000 (2.0), kappa=0 -> done at start+53; w=0x00001555, w0m=0x00000000, w0c=0x00020000, err=0, sat=0.
- alpha=0x20000000 (0.5), beta=0x80000000, kappa=0 -> w=0x00005555, w0m=0xFFFE8001, w0c=0x00014001.
- alpha=0 -> done at start+4; err=1, valid=1, w/w0m/w0c=0.
- alpha=0x00100000 (2^-10), kappa=0 -> w=0x7FFFFFFF, w0m=0x80000000, sat=1.
- start pulsed again at start+10 and inputs changed mid-run -> ignored; results match the first inputs; exactly one done.
- rstn low at start+20 -> all outputs 0 immediately, no done. New start after reset -> correct results.
